// File: rtl/falling_row_ctrl.sv
// falling_row_ctrl: one playfield row of the falling piece; runs fall/spawn/lock/clear/shift ops.
// Latency: non-move ops 3 cycles from accept to done (accept, EVAL, DONE); moves add the HOLD cycles.
// Backpressure: op_ready is high only in IDLE; a move parks in HOLD until the piece-wide commit/abort.
//
// Ports:
//   clk, reset            clock; asynchronous active-high reset
//   op_valid/op_code      op request (valid/ready) and 3-bit op code; op_ready high in IDLE only
//   prev_row, spawn_row   FALL and SPAWN sources
//   field_row, below_row  settled cells in this row and in the row beneath
//   move_commit/abort     piece-wide resolution of a pending LEFT/RIGHT
//   cur_row               registered active bits of this row
//   move_pend/blocked     HOLD indicator and this row's veto of the pending move
//   lock_we/lock_data     one-cycle field write strobe and merged row
//   done                  one-cycle completion pulse
//   stop, row_full        combinational landing and full-row flags
//   endgame               sticky game-over flag, cleared only by reset
module falling_row_ctrl #(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             op_valid,
  input  logic [2:0]       op_code,
  output logic             op_ready,
  input  logic [WIDTH-1:0] prev_row,
  input  logic [WIDTH-1:0] spawn_row,
  input  logic [WIDTH-1:0] field_row,
  input  logic [WIDTH-1:0] below_row,
  input  logic             move_commit,
  input  logic             move_abort,
  output logic [WIDTH-1:0] cur_row,
  output logic             move_pend,
  output logic             move_blocked,
  output logic             lock_we,
  output logic [WIDTH-1:0] lock_data,
  output logic             done,
  output logic             stop,
  output logic             row_full,
  output logic             endgame
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EVAL = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [2:0] OP_NOP   = 3'b000;
  localparam logic [2:0] OP_FALL  = 3'b001;
  localparam logic [2:0] OP_LOCK  = 3'b010;
  localparam logic [2:0] OP_CLEAR = 3'b011;
  localparam logic [2:0] OP_SPAWN = 3'b100;
  localparam logic [2:0] OP_LEFT  = 3'b101;
  localparam logic [2:0] OP_RIGHT = 3'b110;

  logic [1:0]       r_state;
  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_cur;
  logic [WIDTH-1:0] r_cand;
  logic             r_blocked;
  logic             r_lock_we;
  logic [WIDTH-1:0] r_lock_data;
  logic             r_endgame;

  logic [WIDTH-1:0] w_shl;
  logic [WIDTH-1:0] w_shr;
  logic             w_left_blk;
  logic             w_right_blk;
  logic [WIDTH-1:0] w_cand;
  logic             w_load;
  logic             w_blk;
  logic             w_is_move;
  logic             w_spawn_hit;

  // Shifted candidates. A bit falling off the edge is caught by the wall term,
  // so an empty row can never be blocked.
  assign w_shl       = r_cur << 1;
  assign w_shr       = r_cur >> 1;
  assign w_left_blk  = r_cur[WIDTH-1] | (|(w_shl & field_row));
  assign w_right_blk = r_cur[0]       | (|(w_shr & field_row));

  assign w_is_move   = (r_op == OP_LEFT) || (r_op == OP_RIGHT);
  assign w_spawn_hit = (r_op == OP_SPAWN) && (|(spawn_row & field_row));

  // Candidate for the op latched at accept; inputs are sampled during EVAL.
  always_comb begin
    w_cand = r_cur;
    w_load = 1'b0;
    w_blk  = 1'b0;
    case (r_op)
      OP_FALL: begin
        w_cand = prev_row;
        w_load = 1'b1;
      end
      OP_SPAWN: begin
        w_cand = spawn_row;
        w_load = 1'b1;
      end
      OP_LOCK, OP_CLEAR: begin
        w_cand = '0;
        w_load = 1'b1;
      end
      OP_LEFT: begin
        w_cand = w_shl;
        w_blk  = w_left_blk;
      end
      OP_RIGHT: begin
        w_cand = w_shr;
        w_blk  = w_right_blk;
      end
      default: begin
        w_cand = r_cur;
        w_load = 1'b0;
        w_blk  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_op        <= OP_NOP;
      r_cur       <= '0;
      r_cand      <= '0;
      r_blocked   <= 1'b0;
      r_lock_we   <= 1'b0;
      r_lock_data <= '0;
      r_endgame   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (op_valid) begin
            r_op    <= op_code;
            r_state <= S_EVAL;
          end
        end
        S_EVAL: begin
          if (w_is_move) begin
            // Park the shifted row; the other rows of the piece evaluate
            // in the same cycle and the controller commits them together.
            r_cand    <= w_cand;
            r_blocked <= w_blk;
            r_state   <= S_HOLD;
          end else begin
            // After game over the row is frozen: ops still handshake and
            // complete, but neither the row nor the field write changes.
            if (w_load && !r_endgame) begin
              r_cur <= w_cand;
            end
            if ((r_op == OP_LOCK) && !r_endgame) begin
              r_lock_we   <= 1'b1;
              r_lock_data <= field_row | r_cur;
            end
            // An overlapping spawn still loads the row, then ends the game.
            if (w_spawn_hit) begin
              r_endgame <= 1'b1;
            end
            r_state <= S_DONE;
          end
        end
        S_HOLD: begin
          // Abort wins over a simultaneous commit; a commit this row itself
          // blocks leaves the row where it was.
          if (move_abort) begin
            r_blocked <= 1'b0;
            r_state   <= S_DONE;
          end else if (move_commit) begin
            if (!r_blocked && !r_endgame) begin
              r_cur <= r_cand;
            end
            r_blocked <= 1'b0;
            r_state   <= S_DONE;
          end
        end
        S_DONE: begin
          r_lock_we <= 1'b0;
          r_blocked <= 1'b0;
          r_state   <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign op_ready     = (r_state == S_IDLE);
  assign move_pend    = (r_state == S_HOLD);
  assign move_blocked = r_blocked;
  assign done         = (r_state == S_DONE);
  assign cur_row      = r_cur;
  assign lock_we      = r_lock_we;
  assign lock_data    = r_lock_data;
  assign endgame      = r_endgame;
  assign stop         = |(r_cur & below_row);
  assign row_full     = &field_row;

endmodule

// File: tb/tb_falling_row_ctrl.sv
module tb_falling_row_ctrl;

  localparam int W = 10;

  logic         clk = 1'b0;
  logic         reset;
  logic         op_valid;
  logic [2:0]   op_code;
  logic         op_ready;
  logic [W-1:0] prev_row, spawn_row, field_row, below_row;
  logic         move_commit, move_abort;
  logic [W-1:0] cur_row;
  logic         move_pend, move_blocked, lock_we;
  logic [W-1:0] lock_data;
  logic         done, stop, row_full, endgame;

  falling_row_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset),
    .op_valid(op_valid), .op_code(op_code), .op_ready(op_ready),
    .prev_row(prev_row), .spawn_row(spawn_row), .field_row(field_row), .below_row(below_row),
    .move_commit(move_commit), .move_abort(move_abort),
    .cur_row(cur_row), .move_pend(move_pend), .move_blocked(move_blocked),
    .lock_we(lock_we), .lock_data(lock_data), .done(done),
    .stop(stop), .row_full(row_full), .endgame(endgame)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] cur;
    logic         eg;
    logic         lwe;
    logic [W-1:0] ld;
    int           lat;
  } exp_t;

  exp_t sb[$];

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  logic [W-1:0] m_cur = '0;
  logic         m_eg  = 1'b0;
  logic [W-1:0] m_ld  = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Cycle counter and accept timestamp for latency measurement.
  int cyc = 0;
  int acc_cyc = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (op_valid && op_ready) acc_cyc <= cyc;
  end

  // Scoreboard consumer: every done pulse retires one expected result.
  always @(negedge clk) begin
    if (!reset) begin
      if (done) begin
        if (sb.size() == 0) begin
          chk("spurious_done", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("cur_row", 32'(cur_row), 32'(e.cur));
          chk("endgame", 32'(endgame), 32'(e.eg));
          chk("lock_we", 32'(lock_we), 32'(e.lwe));
          chk("lock_data", 32'(lock_data), 32'(e.ld));
          chk("move_pend_done", 32'(move_pend), 0);
          // cycles counted inclusively: accept cycle through done cycle
          chk("latency", 32'(cyc - acc_cyc + 1), 32'(e.lat));
        end
      end else if (lock_we) begin
        chk("lock_we_stray", 1, 0);
      end
    end
  end

  task automatic run_op(input logic [2:0] code, input logic [W-1:0] prev, input logic [W-1:0] spawn,
                        input logic [W-1:0] field, input int hold_n, input logic cmt, input logic abt);
    logic [W-1:0] cand, nxt, ld, sh;
    logic blk, lwe, is_move;
    exp_t e;
    cand = m_cur; nxt = m_cur; ld = m_ld; blk = 1'b0; lwe = 1'b0; is_move = 1'b0;
    case (code)
      3'b001: cand = prev;
      3'b100: cand = spawn;
      3'b010, 3'b011: cand = '0;
      3'b101: begin
        is_move = 1'b1;
        sh = m_cur << 1;
        cand = sh;
        blk = m_cur[W-1] | (|(sh & field));
      end
      3'b110: begin
        is_move = 1'b1;
        sh = m_cur >> 1;
        cand = sh;
        blk = m_cur[0] | (|(sh & field));
      end
      default: cand = m_cur;
    endcase
    if (!is_move) begin
      if (code inside {3'b001, 3'b010, 3'b011, 3'b100}) nxt = cand;
      if (code == 3'b010) begin
        lwe = 1'b1;
        ld  = field | m_cur;
      end
    end else if (cmt && !abt && !blk) begin
      nxt = cand;
    end
    if (m_eg) begin
      nxt = m_cur;
      lwe = 1'b0;
      ld  = m_ld;
    end
    if ((code == 3'b100) && (|(spawn & field))) m_eg = 1'b1;
    m_cur = nxt;
    m_ld  = ld;
    e.cur = nxt; e.eg = m_eg; e.lwe = lwe; e.ld = ld;
    e.lat = is_move ? 3 + hold_n : 3;
    sb.push_back(e);

    @(negedge clk);
    op_valid = 1'b1; op_code = code;
    prev_row = prev; spawn_row = spawn; field_row = field;
    chk("op_ready", 32'(op_ready), 1);
    @(posedge clk);
    #1 op_valid = 1'b0; op_code = 3'b000;
    if (is_move) begin
      @(negedge clk);              // EVAL
      @(negedge clk);              // first HOLD cycle
      chk("move_pend", 32'(move_pend), 1);
      chk("move_blocked", 32'(move_blocked), 32'(blk));
      repeat (hold_n - 1) @(negedge clk);
      move_commit = cmt; move_abort = abt;
      @(posedge clk);
      #1 move_commit = 1'b0; move_abort = 1'b0;
    end
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
    if (sb.size() != 0) begin
      chk("done_timeout", 0, 1);
      sb.delete();
    end
  endtask

  initial begin
    reset = 1'b1; op_valid = 1'b0; op_code = 3'b000;
    prev_row = '0; spawn_row = '0; field_row = '0; below_row = '0;
    move_commit = 1'b0; move_abort = 1'b0;
    #12;
    chk("rst_op_ready", 32'(op_ready), 1);
    chk("rst_cur", 32'(cur_row), 0);
    chk("rst_flags", {27'd0, move_pend, move_blocked, lock_we, done, endgame}, 0);
    chk("rst_lock_data", 32'(lock_data), 0);
    @(negedge clk); reset = 1'b0;

    // Spawn then shifts
    run_op(3'b100, '0, 10'h030, 10'h000, 0, 0, 0);
    run_op(3'b101, '0, '0, 10'h000, 1, 1, 0);          // 0x030 -> 0x060
    run_op(3'b110, '0, '0, 10'h000, 3, 1, 0);          // 3 HOLD cycles, -> 0x030

    below_row = 10'h020; #1 chk("stop_hit", 32'(stop), 1);
    below_row = 10'h100; #1 chk("stop_miss", 32'(stop), 0);
    below_row = '0;

    // Wall-blocked left, then an abort
    run_op(3'b001, 10'h200, '0, '0, 0, 0, 0);
    run_op(3'b101, '0, '0, 10'h000, 1, 1, 0);          // blocked, stays 0x200
    run_op(3'b110, '0, '0, 10'h000, 2, 0, 1);          // abort, stays 0x200

    // Field-blocked right with simultaneous commit and abort
    run_op(3'b001, 10'h006, '0, '0, 0, 0, 0);
    run_op(3'b110, '0, '0, 10'h002, 1, 1, 1);

    // Lock merges into the field and clears the row
    run_op(3'b001, 10'h0F0, '0, '0, 0, 0, 0);
    run_op(3'b010, '0, '0, 10'h30F, 0, 0, 0);
    field_row = 10'h3FF; #1 chk("row_full", 32'(row_full), 1);
    field_row = 10'h3FE; #1 chk("row_not_full", 32'(row_full), 0);

    // Empty row never blocked; right wall; clear; NOPs
    run_op(3'b101, '0, '0, 10'h3FF, 1, 1, 0);
    run_op(3'b001, 10'h001, '0, '0, 0, 0, 0);
    run_op(3'b110, '0, '0, 10'h000, 1, 1, 0);
    run_op(3'b000, 10'h155, 10'h2AA, 10'h0FF, 0, 0, 0);
    run_op(3'b111, 10'h155, 10'h2AA, 10'h0FF, 0, 0, 0);
    run_op(3'b011, '0, '0, '0, 0, 0, 0);

    // Random ops against the model
    for (int k = 0; k < 25; k++) begin
      logic [2:0] c;
      int mode;
      c = 3'($urandom_range(1, 6));
      mode = $urandom_range(0, 2);
      run_op(c, W'($urandom), W'($urandom), W'($urandom) & W'($urandom),
             $urandom_range(1, 3), mode != 1, mode != 0);
    end

    // Reset while a move is pending
    run_op(3'b001, 10'h0C0, '0, '0, 0, 0, 0);
    @(negedge clk);
    op_valid = 1'b1; op_code = 3'b101; field_row = '0;
    @(posedge clk);
    #1 op_valid = 1'b0; op_code = 3'b000;
    @(negedge clk);
    @(negedge clk);
    chk("hold_before_reset", 32'(move_pend), 1);
    #2 reset = 1'b1;
    #1;
    chk("reset_cur", 32'(cur_row), 0);
    chk("reset_move_pend", 32'(move_pend), 0);
    chk("reset_op_ready", 32'(op_ready), 1);
    chk("reset_endgame", 32'(endgame), 0);
    m_cur = '0; m_eg = 1'b0; m_ld = '0;
    @(negedge clk); reset = 1'b0;
    repeat (4) @(negedge clk);

    // Game over: spawn overlap sets endgame, later ops frozen but complete
    run_op(3'b100, '0, 10'h018, 10'h008, 0, 0, 0);
    run_op(3'b001, 10'h001, '0, '0, 0, 0, 0);
    run_op(3'b010, '0, '0, 10'h300, 0, 0, 0);
    run_op(3'b101, '0, '0, 10'h000, 1, 1, 0);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
